wb_master_engine: RTL and testbench
===================================

WB_MASTER_ENGINE -- requirements
Module: wb_master_engine

Interface
REQ-001 Parameter AW, 12, byte-address width of cmd_adr.
REQ-002 Parameter DW, 32, data width (32 or 64); SB = log2(DW/8).
REQ-003 Parameter DEPTH, 4, command FIFO entries (power of 2, >= 2).
REQ-004 Parameter TIMEOUT, 16, maximum cycles cyc/stb stay high awaiting ack/err.
REQ-005 Parameter MAX_RETRY, 2, maximum re-issues after wb_err_i.
REQ-006 The clock SHALL be wb_clk_i (input, 1); the reset SHALL be wb_rst_i (input, 1), synchronous, active-high.
REQ-007 cmd_valid in 1, cmd_ready out 1 SHALL form the command handshake.
REQ-008 cmd_we in 1, cmd_adr in AW, cmd_dat in DW, cmd_sel in DW/8 SHALL carry write flag, byte address, write data and byte enables.
REQ-009 rsp_valid out 1, rsp_ready in 1 SHALL form the response handshake.
REQ-010 rsp_dat out DW, rsp_err out 1, rsp_tmo out 1 SHALL carry read data, bus error and timeout status.
REQ-011 wb_adr_o out AW-SB, wb_dat_o out DW, wb_sel_o out DW/8, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1 SHALL drive the Wishbone slave.
REQ-012 wb_dat_i in DW, wb_ack_i in 1, wb_err_i in 1 SHALL be the slave responses.
REQ-013 busy out 1 SHALL be high while the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-014 A command SHALL be pushed on any edge with cmd_valid && cmd_ready; cmd_ready = !full, so a push attempted while full SHALL be refused even if a pop occurs in the same cycle.
REQ-015 FSM states SHALL be IDLE, BUS, RETRY, RESP.
REQ-016 IDLE: with the FIFO non-empty, on the next edge the engine SHALL pop the head, register wb_adr_o = cmd_adr[AW-1:SB], wb_dat_o, wb_sel_o, wb_we_o, raise wb_cyc_o and wb_stb_o together, and enter BUS.
REQ-017 Latency: a command pushed into an empty, idle engine at edge N SHALL have cyc/stb high after edge N+1.
REQ-018 BUS: wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o SHALL stay constant; cyc and stb SHALL always be equal.
REQ-019 BUS with wb_ack_i (and no wb_err_i): on that edge cyc/stb SHALL drop, rsp_dat SHALL capture wb_dat_i on reads and take 0 on writes, rsp_err = rsp_tmo = 0, and the FSM SHALL enter RESP.
REQ-020 BUS with wb_ack_i and wb_err_i asserted together SHALL be treated as an error.
REQ-021 A timeout counter SHALL clear on entering BUS and increment each BUS cycle; if TIMEOUT cycles pass without ack or err, cyc/stb SHALL drop and the FSM SHALL enter RESP with rsp_tmo = 1, rsp_err = 0, rsp_dat = 0; a timeout SHALL never be retried.
REQ-022 RESP: rsp_valid SHALL be 1 with all rsp_* outputs stable until rsp_ready; on that handshake the FSM SHALL enter IDLE and rsp_valid SHALL fall.
REQ-023 Outside BUS, wb_cyc_o and wb_stb_o SHALL be 0, and the other wb_* outputs SHALL hold their last values.

Reset
REQ-024 On wb_rst_i, at the edge: wb_* outputs 0; rsp_valid, rsp_dat, rsp_err, rsp_tmo 0; FIFO empty; cmd_ready 1; state IDLE; counters 0.
REQ-025 Reset during BUS, RETRY or RESP SHALL abort the cycle, discard all queued and in-flight commands, and produce no response.

Configuration
REQ-026 Macro WB_MASTER_RETRY_EN defined: wb_err_i in BUS with retry count < MAX_RETRY SHALL drop cyc/stb for one cycle (RETRY), increment the count, clear the timeout counter, then re-issue the identical cycle.
REQ-027 With the macro defined, the error after MAX_RETRY re-issues SHALL enter RESP with rsp_err = 1; the retry count SHALL clear on each IDLE-to-BUS entry.
REQ-028 Macro undefined: wb_err_i SHALL enter RESP immediately with rsp_err = 1; RETRY state and MAX_RETRY SHALL be unused.

Structure
REQ-029 Package wb_master_pkg SHALL hold the default constants WB_ADDR_WIDTH and WB_DATA_WIDTH and the state enum wb_ms_state_e.
REQ-030 The command FIFO SHALL be the sub-module wb_master_cmd_fifo (synchronous, parameters DEPTH and width, with full/empty outputs).

Verification (AW=12, DW=32, DEPTH=4, TIMEOUT=16, MAX_RETRY=2)
REQ-031 Write adr 0x048, dat 0xDEADBEEF, sel 0xF, ack after 2 stall cycles -> wb_adr_o = 0x012, wb_we_o = 1, cyc high 3 cycles, rsp_err = rsp_tmo = 0.
REQ-032 Read adr 0x040, slave acks with 0x0000A000 -> rsp_dat = 0x0000A000, held until rsp_ready.
REQ-033 Slave never acks, 6 back-to-back pushes -> 1 on bus, 4 queued, 6th refused with cmd_ready = 0.
REQ-034 No ack or err -> cyc high exactly 16 cycles, then rsp_tmo = 1.
REQ-035 err on attempts 1-2, ack on attempt 3 -> macro defined: 3 cyc pulses separated by 1 idle cycle, rsp_err = 0; macro undefined: 1 pulse, rsp_err = 1.
REQ-036 Reset asserted in BUS with 2 queued -> cyc/stb 0 after that edge, rsp_valid never rises, cmd_ready = 1.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared defaults and FSM encoding for the Wishbone master engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_master_pkg;

    localparam int WB_ADDR_WIDTH = 12;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RETRY = 2'd2,
        RESP  = 2'd3
    } wb_ms_state_e;

endpackage

// File: rtl/wb_master_cmd_fifo.sv
// Synchronous command queue, DEPTH entries of WIDTH bits, head presented combinationally.
// Latency: an entry pushed at edge N is visible on pop_dat after edge N.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module wb_master_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_dat = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/wb_master_engine.sv
// Wishbone classic master: queues commands, runs one bus cycle each (timeout; retry on err with WB_MASTER_RETRY_EN).
// Latency: command pushed into an idle, empty engine at edge N drives cyc/stb high after edge N+1.
// Backpressure: cmd_ready = !fifo full; each response is held in RESP until rsp_ready.
module wb_master_engine
    import wb_master_pkg::*;
#(
    parameter int AW        = WB_ADDR_WIDTH,
    parameter int DW        = WB_DATA_WIDTH,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [AW-1:0]            cmd_adr,
    input  logic [DW-1:0]            cmd_dat,
    input  logic [DW/8-1:0]          cmd_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_dat,
    output logic                     rsp_err,
    output logic                     rsp_tmo,
    output logic [AW-$clog2(DW/8)-1:0] wb_adr_o,
    output logic [DW-1:0]            wb_dat_o,
    output logic [DW/8-1:0]          wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic [DW-1:0]            wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    output logic                     busy
);

    localparam int SB  = $clog2(DW/8);
    localparam int SW  = DW/8;
    localparam int WAW = AW - SB;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic           we;
        logic [WAW-1:0] adr;
        logic [DW-1:0]  dat;
        logic [SW-1:0]  sel;
    } cmd_t;

    cmd_t         in_cmd;
    cmd_t         head_cmd;
    logic         full;
    logic         empty;
    logic         pop;

    wb_ms_state_e   state_q, state_d;
    logic [WAW-1:0] adr_q, adr_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic           we_q, we_d;
    logic           cyc_q, cyc_d;
    logic [DW-1:0]  rdat_q, rdat_d;
    logic           rerr_q, rerr_d;
    logic           rtmo_q, rtmo_d;
    logic [TW-1:0]  tmo_q, tmo_d;

`ifdef WB_MASTER_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = (MAX_RETRY > 0);
`endif

    // Byte-lane bits below the word address never reach the bus.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^cmd_adr[SB-1:0];

    assign cmd_ready = !full;
    assign in_cmd    = '{we: cmd_we, adr: cmd_adr[AW-1:SB], dat: cmd_dat, sel: cmd_sel};

    wb_master_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .push     (cmd_valid),
        .push_dat (in_cmd),
        .pop      (pop),
        .pop_dat  (head_cmd),
        .full     (full),
        .empty    (empty)
    );

    // Next-state and next-output logic; cyc defaults low so every non-BUS state drops it.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = 1'b0;
        rdat_d  = rdat_q;
        rerr_d  = rerr_q;
        rtmo_d  = rtmo_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
`ifdef WB_MASTER_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    adr_d   = head_cmd.adr;
                    dat_d   = head_cmd.dat;
                    sel_d   = head_cmd.sel;
                    we_d    = head_cmd.we;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = BUS;
`ifdef WB_MASTER_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            BUS: begin
                if (wb_err_i) begin
`ifdef WB_MASTER_RETRY_EN
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        tmo_d   = '0;
                        state_d = RETRY;
                    end else begin
                        rdat_d  = '0;
                        rerr_d  = 1'b1;
                        rtmo_d  = 1'b0;
                        state_d = RESP;
                    end
`else
                    rdat_d  = '0;
                    rerr_d  = 1'b1;
                    rtmo_d  = 1'b0;
                    state_d = RESP;
`endif
                end else if (wb_ack_i) begin
                    rdat_d  = we_q ? '0 : wb_dat_i;
                    rerr_d  = 1'b0;
                    rtmo_d  = 1'b0;
                    state_d = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rdat_d  = '0;
                    rerr_d  = 1'b0;
                    rtmo_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cyc_d   = 1'b1;
                    tmo_d   = tmo_q + 1'b1;
                end
            end
`ifdef WB_MASTER_RETRY_EN
            RETRY: begin
                cyc_d   = 1'b1;
                state_d = BUS;
            end
`endif
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus/response outputs; reset abandons any cycle in flight.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
            rtmo_q  <= 1'b0;
            tmo_q   <= '0;
`ifdef WB_MASTER_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdat_q  <= rdat_d;
            rerr_q  <= rerr_d;
            rtmo_q  <= rtmo_d;
            tmo_q   <= tmo_d;
`ifdef WB_MASTER_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_dat   = rdat_q;
    assign rsp_err   = rerr_q;
    assign rsp_tmo   = rtmo_q;
    assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_engine.sv
// Randomized scoreboard bench for wb_master_engine with a scripted Wishbone slave.
// Each command carries a per-attempt slave script; the model derives the bus attempts and final response.
// Bus monitor and response monitor pop expectations independently of the stimulus thread.
module tb_wb_master_engine;

    localparam int AW = 12, DW = 32, DEPTH = 4, TIMEOUT = 16, MAX_RETRY = 2;
    localparam int K_ACK = 0, K_ERR = 1, K_NONE = 2, K_BOTH = 3;

    typedef struct {
        logic        we;
        logic [11:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          kind  [3];
        int          stall [3];
        logic [31:0] rdata [3];
    } cmd_t;

    typedef struct {
        logic [9:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          kind;
        int          stall;
        logic [31:0] rdata;
        bit          retry;
    } att_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [11:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_dat;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, busy;

    int total = 0;
    int bad   = 0;
    att_t att_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    wb_master_engine #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr  (cmd_adr),  .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err  (rsp_err),  .rsp_tmo  (rsp_tmo),
        .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o),  .wb_sel_o(wb_sel_o),
        .wb_we_o  (wb_we_o),  .wb_cyc_o (wb_cyc_o),  .wb_stb_o(wb_stb_o),
        .wb_dat_i (wb_dat_i), .wb_ack_i (wb_ack_i),  .wb_err_i(wb_err_i),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the slave script attempt by attempt using the retry allowance.
    task automatic model_push(input cmd_t c);
        att_t a;
        rsp_t r;
        int   allow;
`ifdef WB_MASTER_RETRY_EN
        allow = MAX_RETRY;
`else
        allow = 0;
`endif
        r = '{dat: 32'h0, err: 1'b1, tmo: 1'b0};
        for (int i = 0; i <= allow; i++) begin
            a.adr   = 10'(c.adr >> 2);
            a.we    = c.we;
            a.dat   = c.dat;
            a.sel   = c.sel;
            a.kind  = c.kind[i];
            a.stall = c.stall[i];
            a.rdata = c.rdata[i];
            a.retry = (i > 0);
            att_q.push_back(a);
            if (a.kind == K_ACK) begin
                r = '{dat: (c.we ? 32'h0 : c.rdata[i]), err: 1'b0, tmo: 1'b0};
                break;
            end
            if (a.kind == K_NONE) begin
                r = '{dat: 32'h0, err: 1'b0, tmo: 1'b1};
                break;
            end
        end
        rsp_q.push_back(r);
    endtask

    task automatic push_cmd(input cmd_t c);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = c.we;
        cmd_adr   = c.adr;
        cmd_dat   = c.dat;
        cmd_sel   = c.sel;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("push_wait_ready", 64'(cmd_ready), 64'd1);
        else model_push(c);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || att_q.size() != 0 || rsp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 3000), 64'd0);
    endtask

    function automatic cmd_t mk(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                                input int k0, input int k1, input int k2, input int st,
                                input logic [31:0] rd);
        cmd_t c;
        c.we = we; c.adr = adr; c.dat = dat; c.sel = 4'hF;
        c.kind[0] = k0; c.kind[1] = k1; c.kind[2] = k2;
        for (int i = 0; i < 3; i++) begin
            c.stall[i] = st;
            c.rdata[i] = rd;
        end
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   p;
        c.we  = 1'($urandom_range(0, 1));
        c.adr = 12'($urandom);
        c.dat = $urandom;
        c.sel = 4'($urandom_range(1, 15));
        for (int i = 0; i < 3; i++) begin
            p = int'($urandom_range(0, 99));
            c.kind[i]  = (p < 55) ? K_ACK : (p < 80) ? K_ERR : (p < 92) ? K_BOTH : K_NONE;
            c.stall[i] = int'($urandom_range(0, 3));
            c.rdata[i] = $urandom;
        end
        return c;
    endfunction

    // Scripted slave and bus monitor: checks each attempt's fields, length and retry gap.
    initial begin : slave
        att_t cur;
        bit   active = 0;
        bit   bogus  = 0;
        int   cnt    = 0;
        int   gap    = 0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
            if (rst) begin
                active = 0;
                gap    = 0;
            end else if (wb_cyc_o) begin
                if (!active) begin
                    active = 1;
                    cnt    = 0;
                    bogus  = (att_q.size() == 0);
                    if (bogus) begin
                        total++; bad++;
                        $display("FAIL unexpected_bus_cycle: got cyc=1, required no cycle");
                    end else begin
                        cur = att_q.pop_front();
                        if (cur.retry) chk("retry_gap", 64'(gap), 64'd1);
                    end
                end
                cnt++;
                if (!bogus) begin
                    chk("wb_stb", 64'(wb_stb_o), 64'd1);
                    chk("wb_adr", 64'(wb_adr_o), 64'(cur.adr));
                    chk("wb_we",  64'(wb_we_o),  64'(cur.we));
                    chk("wb_dat", 64'(wb_dat_o), 64'(cur.dat));
                    chk("wb_sel", 64'(wb_sel_o), 64'(cur.sel));
                    if (cur.kind != K_NONE && cnt == cur.stall + 1) begin
                        wb_ack_i = (cur.kind == K_ACK || cur.kind == K_BOTH);
                        wb_err_i = (cur.kind == K_ERR || cur.kind == K_BOTH);
                        wb_dat_i = cur.rdata;
                    end
                end
            end else begin
                if (active && !bogus)
                    chk("cyc_len", 64'(cnt), 64'(cur.kind == K_NONE ? TIMEOUT : cur.stall + 1));
                if (active) gap = 0;
                active = 0;
                gap++;
                chk("stb_low", 64'(wb_stb_o), 64'd0);
            end
        end
    end

    // Response monitor: randomized rsp_ready, head compared every cycle while valid, popped on handshake.
    initial begin : monitor
        rsp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = ($urandom_range(0, 99) < 70);
            if (!rst && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, required 0");
                end else begin
                    e = rsp_q[0];
                    chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
                    if (rsp_ready) void'(rsp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, required test end");
        $fatal(1);
    end

    initial begin : stim
        cmd_t c;
        bit   seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc",       64'(wb_cyc_o),  64'd0);
        chk("rst_adr",       64'(wb_adr_o),  64'd0);
        chk("rst_dat",       64'(wb_dat_o),  64'd0);
        chk("rst_we_sel",    64'({wb_we_o, wb_sel_o}), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp",       64'({rsp_dat, rsp_err, rsp_tmo}), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write with 2 stall cycles, plus first-transaction latency.
        c = mk(1'b1, 12'h048, 32'hDEADBEEF, K_ACK, K_ACK, K_ACK, 2, 32'h0);
        push_cmd(c);
        chk("lat_push_edge", 64'(wb_cyc_o), 64'd0);
        @(posedge clk);
        #1 chk("lat_next_edge", 64'(wb_cyc_o), 64'd1);
        wait_idle();

        // Read returning 0x0000A000.
        push_cmd(mk(1'b0, 12'h040, 32'h0, K_ACK, K_ACK, K_ACK, 1, 32'h0000A000));
        wait_idle();

        // Silent slave: timeout.
        push_cmd(mk(1'b0, 12'h104, 32'h5, K_NONE, K_NONE, K_NONE, 0, 32'h0));
        wait_idle();

        // Err, err, ack.
        push_cmd(mk(1'b0, 12'h0FC, 32'h7, K_ERR, K_ERR, K_ACK, 1, 32'h00001234));
        wait_idle();

        // Fill the queue behind a stuck cycle; the 6th push must wait for a free slot.
        push_cmd(mk(1'b1, 12'h200, 32'h11, K_NONE, K_NONE, K_NONE, 0, 32'h0));
        for (int i = 0; i < 4; i++)
            push_cmd(mk(1'b1, 12'(12'h210 + 4 * i), 32'(i), K_ACK, K_ACK, K_ACK, 0, 32'h0));
        @(negedge clk);
        chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("full_cyc",       64'(wb_cyc_o),  64'd1);
        push_cmd(mk(1'b0, 12'h300, 32'h66, K_ACK, K_ACK, K_ACK, 0, 32'hCAFE0006));
        wait_idle();

        // Randomized traffic with random inter-command gaps.
        for (int i = 0; i < 40; i++) begin
            push_cmd(rand_cmd());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset while a cycle is on the bus with two queued.
        for (int i = 0; i < 3; i++)
            push_cmd(mk(1'b1, 12'(12'h400 + 4 * i), 32'(i), K_NONE, K_NONE, K_NONE, 0, 32'h0));
        @(negedge clk);
        chk("pre_rst_cyc",  64'(wb_cyc_o), 64'd1);
        chk("pre_rst_full", 64'(cmd_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        att_q.delete();
        rsp_q.delete();
        chk("mid_rst_cyc",       64'(wb_cyc_o),  64'd0);
        chk("mid_rst_stb",       64'(wb_stb_o),  64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o) seen = 1;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
